cached_dmem: RTL and testbench

//  Data-memory subsystem for the pipelined MIPS core: 32-bit word port with byte-enable writes,

---
 rtl/cached_dmem_if.sv | 27 ++
 rtl/cached_dmem.sv | 190 +++++++++++++++++++
 tb/tb_cached_dmem.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cached_dmem_if.sv
// Core-side data-memory bus: init/preload port plus the load/store request
// port. The core (master) drives the i_* signals and the memory subsystem
// (slave) drives the o_* signals.
interface cached_dmem_if;
    logic        i_dmem_init_done;
    logic [3:0]  i_dmem_init_wen;
    logic [31:0] i_dmem_init_addr;
    logic [31:0] i_dmem_init_data;
    logic        i_dmem_ren;
    logic [3:0]  i_dmem_wen;
    logic [31:0] i_dmem_addr;
    logic [31:0] i_dmem_data;
    logic [31:0] o_dmem_data;
    logic        o_dmem_stall;

    modport master (
        output i_dmem_init_done, i_dmem_init_wen, i_dmem_init_addr, i_dmem_init_data,
        output i_dmem_ren, i_dmem_wen, i_dmem_addr, i_dmem_data,
        input  o_dmem_data, o_dmem_stall
    );

    modport slave (
        input  i_dmem_init_done, i_dmem_init_wen, i_dmem_init_addr, i_dmem_init_data,
        input  i_dmem_ren, i_dmem_wen, i_dmem_addr, i_dmem_data,
        output o_dmem_data, o_dmem_stall
    );
endinterface

// File: rtl/cached_dmem.sv
// Data-memory subsystem: direct-mapped, write-back, write-allocate cache in
// front of a line-wide backing store that models DRAM with a fixed latency.
// Misses freeze the core through o_dmem_stall until the line is resident.
module cached_dmem #(
    parameter int unsigned APP_ADDR_WIDTH = 28,
    parameter int unsigned APP_CMD_WIDTH  = 3,
    parameter int unsigned APP_DATA_WIDTH = 128,
    parameter int unsigned APP_MASK_WIDTH = 16,
    parameter int unsigned CACHE_LINES    = 64,
    parameter int unsigned MEM_LINES      = 4096,
    parameter int unsigned MEM_LATENCY    = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    cached_dmem_if.slave dmem
);
    localparam int unsigned LINE_WORDS = APP_DATA_WIDTH / 32;
    localparam int unsigned OFF_W      = $clog2(APP_DATA_WIDTH / 8);
    localparam int unsigned WSEL_W     = $clog2(LINE_WORDS);
    localparam int unsigned IDX_W      = $clog2(CACHE_LINES);
    localparam int unsigned LADDR_W    = APP_ADDR_WIDTH - OFF_W;
    localparam int unsigned TAG_W      = LADDR_W - IDX_W;
    localparam int unsigned MIDX_W     = $clog2(MEM_LINES);
    localparam int unsigned CNT_W      = $clog2(MEM_LATENCY + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITEBACK,
        ST_FILL
    } state_t;

    // Byte-lane mask for one 32-bit word placed at word slot wsel of a line.
    function automatic logic [APP_MASK_WIDTH-1:0] line_mask(
        input logic [WSEL_W-1:0] wsel,
        input logic [3:0]        wen
    );
        return APP_MASK_WIDTH'(wen) << {wsel, 2'b00};
    endfunction

    // Replace the masked bytes of a line with the matching bytes of a word.
    function automatic logic [APP_DATA_WIDTH-1:0] merge_bytes(
        input logic [APP_DATA_WIDTH-1:0] old_line,
        input logic [31:0]               word,
        input logic [APP_MASK_WIDTH-1:0] mask
    );
        logic [APP_DATA_WIDTH-1:0] rep;
        rep = {LINE_WORDS{word}};
        merge_bytes = old_line;
        for (int b = 0; b < int'(APP_MASK_WIDTH); b++) begin
            if (mask[b]) merge_bytes[8*b +: 8] = rep[8*b +: 8];
        end
    endfunction

    // The backing store wraps: the line index is taken modulo MEM_LINES.
    function automatic logic [MIDX_W-1:0] mem_index(input logic [LADDR_W-1:0] line);
        return MIDX_W'(line);
    endfunction

    // Backing store and cache arrays.
    logic [APP_DATA_WIDTH-1:0] mem        [MEM_LINES];
    logic [APP_DATA_WIDTH-1:0] cache_data [CACHE_LINES];
    logic [TAG_W-1:0]          tag_q      [CACHE_LINES];
    logic [CACHE_LINES-1:0]    valid_q;
    logic [CACHE_LINES-1:0]    dirty_q;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [IDX_W-1:0]   miss_idx;
    logic [TAG_W-1:0]   miss_tag;
    logic [31:0]        rdata_q;

    // Request decode.
    logic               init_done;
    logic               request;
    logic               hit;
    logic               accept;
    logic               lat_done;
    logic               wb_done;
    logic               fill_done;
    logic [LADDR_W-1:0] req_line;
    logic [IDX_W-1:0]   req_idx;
    logic [TAG_W-1:0]   req_tag;
    logic [WSEL_W-1:0]  req_wsel;
    logic [31:0]        cur_word;

    assign init_done = dmem.i_dmem_init_done;
    assign req_line  = dmem.i_dmem_addr[APP_ADDR_WIDTH-1:OFF_W];
    assign req_idx   = req_line[IDX_W-1:0];
    assign req_tag   = req_line[LADDR_W-1:IDX_W];
    assign req_wsel  = dmem.i_dmem_addr[OFF_W-1:2];
    assign cur_word  = cache_data[req_idx][{req_wsel, 5'b00000} +: 32];

    assign request   = dmem.i_dmem_ren || (|dmem.i_dmem_wen);
    assign hit       = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign accept    = init_done && (state == ST_IDLE) && request && hit;
    assign lat_done  = (cnt == CNT_W'(MEM_LATENCY - 1));
    assign wb_done   = !i_rst && init_done && (state == ST_WRITEBACK) && lat_done;
    assign fill_done = !i_rst && init_done && (state == ST_FILL) && lat_done;

    assign dmem.o_dmem_stall = !init_done || (state != ST_IDLE) || (request && !hit);
    assign dmem.o_dmem_data  = rdata_q;

    // Ignored address bits and the reserved DRAM command field.
    logic                     unused_addr_bits;
    logic [APP_CMD_WIDTH-1:0] unused_app_cmd;
    assign unused_addr_bits = ^{dmem.i_dmem_addr[31:APP_ADDR_WIDTH], dmem.i_dmem_addr[1:0],
                                dmem.i_dmem_init_addr[31:APP_ADDR_WIDTH],
                                dmem.i_dmem_init_addr[1:0]};
    assign unused_app_cmd   = '0;

    // Backing store writes: init-port preload or the end of a victim writeback.
    // NOTE: storage arrays carry no reset; only the valid/dirty bits and FSM
    // need a known state, and reset must not disturb the backing store anyway.
    always_ff @(posedge i_clk) begin
        if (!init_done) begin
            mem[mem_index(dmem.i_dmem_init_addr[APP_ADDR_WIDTH-1:OFF_W])] <=
                merge_bytes(mem[mem_index(dmem.i_dmem_init_addr[APP_ADDR_WIDTH-1:OFF_W])],
                            dmem.i_dmem_init_data,
                            line_mask(dmem.i_dmem_init_addr[OFF_W-1:2], dmem.i_dmem_init_wen));
        end else if (wb_done) begin
            mem[mem_index({tag_q[miss_idx], miss_idx})] <= cache_data[miss_idx];
        end
    end

    // Cache tag/data arrays: store hits merge bytes, a completed fill loads a line.
    always_ff @(posedge i_clk) begin
        if (fill_done) begin
            tag_q[miss_idx]      <= miss_tag;
            cache_data[miss_idx] <= mem[mem_index({miss_tag, miss_idx})];
        end else if (!i_rst && accept && (|dmem.i_dmem_wen)) begin
            cache_data[req_idx] <= merge_bytes(cache_data[req_idx], dmem.i_dmem_data,
                                               line_mask(req_wsel, dmem.i_dmem_wen));
        end
    end

    // Miss FSM, line status bits and the registered read data.
    // NOTE: all state here updates with <= so every branch sees the values
    // from before the edge (a read+write hit returns the pre-write word).
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            valid_q <= '0;
            dirty_q <= '0;
            rdata_q <= '0;
        end else if (!init_done) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (request && !hit) begin
                        miss_idx <= req_idx;
                        miss_tag <= req_tag;
                        cnt      <= '0;
                        state    <= (valid_q[req_idx] && dirty_q[req_idx]) ? ST_WRITEBACK
                                                                             : ST_FILL;
                    end else if (accept) begin
                        if (dmem.i_dmem_ren) rdata_q <= cur_word;
                        if (|dmem.i_dmem_wen) dirty_q[req_idx] <= 1'b1;
                    end
                end
                ST_WRITEBACK: begin
                    if (lat_done) begin
                        cnt   <= '0;
                        state <= ST_FILL;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_FILL: begin
                    if (lat_done) begin
                        valid_q[miss_idx] <= 1'b1;
                        dirty_q[miss_idx] <= 1'b0;
                        cnt               <= '0;
                        state             <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cached_dmem.sv
// Self-checking bench for cached_dmem: directed scenarios followed by random
// loads/stores against a reference model of the architectural memory view,
// the backing store and a cache directory used to predict stall lengths.
module tb_cached_dmem;
    localparam int LAT = 8;
    localparam int CL  = 64;
    localparam int ML  = 4096;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;

    always #5 i_clk = ~i_clk;

    cached_dmem_if bus ();

    cached_dmem #(
        .APP_ADDR_WIDTH (28),
        .APP_CMD_WIDTH  (3),
        .APP_DATA_WIDTH (128),
        .APP_MASK_WIDTH (16),
        .CACHE_LINES    (CL),
        .MEM_LINES      (ML),
        .MEM_LATENCY    (LAT)
    ) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .dmem  (bus)
    );

    int n_compared = 0;
    int n_mismatch = 0;

    // Reference model: am = what the core should observe, bs = backing store,
    // d_* = which line each cache index holds and whether it is dirty.
    logic [31:0] am [int];
    logic [31:0] bs [int];
    bit          d_valid [CL];
    bit          d_dirty [CL];
    int          d_line  [CL];
    logic [31:0] last_rd = 32'h0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatch++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] bs_get(input int wa);
        int k = wa % (ML * 4);
        return bs.exists(k) ? bs[k] : 32'h0;
    endfunction

    function automatic logic [31:0] am_get(input int wa);
        return am.exists(wa) ? am[wa] : bs_get(wa);
    endfunction

    function automatic logic [31:0] merge_word(input logic [31:0] old_w, input logic [3:0] wen,
                                               input logic [31:0] data);
        logic [31:0] r = old_w;
        for (int k = 0; k < 4; k++) if (wen[k]) r[8*k +: 8] = data[8*k +: 8];
        return r;
    endfunction

    // Returns the expected number of stall cycles and updates the directory.
    function automatic int model_access(input logic [31:0] addr);
        int line = int'(addr[27:4]);
        int idx  = line % CL;
        int st   = LAT + 1;
        if (d_valid[idx] && d_line[idx] == line) return 0;
        if (d_valid[idx] && d_dirty[idx]) begin
            for (int w = 0; w < 4; w++)
                bs[(d_line[idx] * 4 + w) % (ML * 4)] = am_get(d_line[idx] * 4 + w);
            st = 2 * LAT + 1;
        end
        for (int w = 0; w < 4; w++) am[line * 4 + w] = bs_get(line * 4 + w);
        d_valid[idx] = 1'b1;
        d_dirty[idx] = 1'b0;
        d_line[idx]  = line;
        return st;
    endfunction

    function automatic void model_write(input logic [31:0] addr, input logic [3:0] wen,
                                        input logic [31:0] data);
        int wa = int'(addr[27:2]);
        am[wa] = merge_word(am_get(wa), wen, data);
        d_dirty[int'(addr[27:4]) % CL] = 1'b1;
    endfunction

    // Reset drops dirty lines: the core sees the backing-store contents again.
    function automatic void model_reset();
        for (int i = 0; i < CL; i++) begin
            if (d_valid[i] && d_dirty[i])
                for (int w = 0; w < 4; w++) am[d_line[i] * 4 + w] = bs_get(d_line[i] * 4 + w);
            d_valid[i] = 1'b0;
            d_dirty[i] = 1'b0;
        end
    endfunction

    // Called just after a rising edge; leaves just after a rising edge.
    task automatic init_write(input logic [31:0] addr, input logic [3:0] wen,
                              input logic [31:0] data, input bit chk);
        int wa = int'(addr[27:2]);
        bs[wa % (ML * 4)] = merge_word(bs_get(wa), wen, data);
        am[wa] = bs_get(wa);
        bus.i_dmem_init_addr = addr;
        bus.i_dmem_init_wen  = wen;
        bus.i_dmem_init_data = data;
        @(negedge i_clk);
        if (chk) check("init stall", {31'b0, bus.o_dmem_stall}, 32'h1);
        @(posedge i_clk);
        #1;
        bus.i_dmem_init_wen = 4'h0;
    endtask

    // Issue one request, count stall cycles, then check stall count and read data.
    task automatic do_req(input string tag, input logic ren, input logic [3:0] wen,
                          input logic [31:0] addr, input logic [31:0] data,
                          output int stalls);
        int          exp_st;
        logic [31:0] exp_rd;
        exp_st = model_access(addr);
        exp_rd = am_get(int'(addr[27:2]));
        if (|wen) model_write(addr, wen, data);
        bus.i_dmem_ren  = ren;
        bus.i_dmem_wen  = wen;
        bus.i_dmem_addr = addr;
        bus.i_dmem_data = data;
        stalls = 0;
        @(negedge i_clk);
        while (bus.o_dmem_stall && stalls < 100) begin
            stalls++;
            @(negedge i_clk);
        end
        check({tag, " stall"}, 32'(stalls), 32'(exp_st));
        @(posedge i_clk);
        #1;
        bus.i_dmem_ren = 1'b0;
        bus.i_dmem_wen = 4'h0;
        if (ren) last_rd = exp_rd;
        check({tag, ren ? " rdata" : " hold"}, bus.o_dmem_data, last_rd);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (observed timeout, expected finish)");
        $fatal(1);
    end

    initial begin
        int          st;
        logic [31:0] a;
        logic [3:0]  w;
        int          op;

        bus.i_dmem_init_done = 1'b0;
        bus.i_dmem_init_wen  = 4'h0;
        bus.i_dmem_init_addr = 32'h0;
        bus.i_dmem_init_data = 32'h0;
        bus.i_dmem_ren       = 1'b0;
        bus.i_dmem_wen       = 4'h0;
        bus.i_dmem_addr      = 32'h0;
        bus.i_dmem_data      = 32'h0;
        model_reset();

        // Reset state.
        repeat (3) @(posedge i_clk);
        #1;
        check("reset rdata", bus.o_dmem_data, 32'h0);
        check("reset stall", {31'b0, bus.o_dmem_stall}, 32'h1);
        i_rst = 1'b0;

        // Test 1: preload, then the first read misses with a clean fill.
        init_write(32'h0000_0000, 4'hF, 32'h1122_3344, 1'b1);
        init_write(32'h0000_001C, 4'hF, 32'hAABB_CCDD, 1'b1);
        init_write(32'h0000_00A8, 4'hF, 32'h5A5A_1234, 1'b0);
        for (int t = 2; t < 6; t++)
            for (int i = 0; i < 4; i++)
                for (int k = 0; k < 4; k++)
                    init_write(32'(t * 1024 + i * 16 + k * 4), 4'hF, $urandom, 1'b0);
        init_write(32'h0000_0804, 4'b0101, 32'hC3C3_C3C3, 1'b1);
        bus.i_dmem_ren  = 1'b1;
        bus.i_dmem_addr = 32'h0;
        @(negedge i_clk);
        check("init ignores ren", {31'b0, bus.o_dmem_stall}, 32'h1);
        @(posedge i_clk);
        #1;
        check("init rdata hold", bus.o_dmem_data, 32'h0);
        bus.i_dmem_ren       = 1'b0;
        bus.i_dmem_init_done = 1'b1;
        @(negedge i_clk);
        check("idle no request", {31'b0, bus.o_dmem_stall}, 32'h0);
        @(posedge i_clk);
        #1;

        do_req("t1 read 0x0", 1'b1, 4'h0, 32'h0, 32'h0, st);
        check("t1 stall const", 32'(st), 32'(LAT + 1));
        check("t1 data const", bus.o_dmem_data, 32'h1122_3344);

        // Test 2: same line hit, uninitialised word.
        do_req("t2 read 0x4", 1'b1, 4'h0, 32'h4, 32'h0, st);
        check("t2 data const", bus.o_dmem_data, 32'h0);

        // Test 3: byte write hit, then read back.
        do_req("t3 write", 1'b0, 4'b0010, 32'h0, 32'h0000_EE00, st);
        do_req("t3 read", 1'b1, 4'h0, 32'h0, 32'h0, st);
        check("t3 data const", bus.o_dmem_data, 32'h1122_EE44);

        // Test 4: conflicting tag forces a dirty writeback, then refill the original.
        do_req("t4 conflict", 1'b1, 4'h0, 32'(CL * 16), 32'h0, st);
        check("t4 stall const", 32'(st), 32'(2 * LAT + 1));
        do_req("t4 reread", 1'b1, 4'h0, 32'h0, 32'h0, st);
        check("t4 data const", bus.o_dmem_data, 32'h1122_EE44);

        // Test 5: simultaneous read+write on a hit returns the pre-write word.
        do_req("t5 bring in", 1'b1, 4'h0, 32'h1C, 32'h0, st);
        do_req("t5 rw", 1'b1, 4'hF, 32'h1C, 32'hDEAD_BEEF, st);
        check("t5 rw old data", bus.o_dmem_data, 32'hAABB_CCDD);
        do_req("t5 read", 1'b1, 4'h0, 32'h1C, 32'h0, st);
        check("t5 new data", bus.o_dmem_data, 32'hDEAD_BEEF);

        // Random loads/stores over four conflicting tags and four indices.
        for (int n = 0; n < 200; n++) begin
            a  = 32'((2 + $urandom_range(3)) * 1024 + $urandom_range(3) * 16
                     + $urandom_range(3) * 4);
            op = $urandom_range(2);
            w  = 4'($urandom_range(15, 1));
            case (op)
                0:       do_req("rand read", 1'b1, 4'h0, a, 32'h0, st);
                1:       do_req("rand write", 1'b0, w, a, $urandom, st);
                default: do_req("rand rw", 1'b1, w, a, $urandom, st);
            endcase
        end

        // Test 6: reset in the middle of a fill.
        bus.i_dmem_ren  = 1'b1;
        bus.i_dmem_addr = 32'h0000_00A8;
        repeat (3) @(posedge i_clk);
        #1;
        check("t6 stalled in fill", {31'b0, bus.o_dmem_stall}, 32'h1);
        bus.i_dmem_ren = 1'b0;
        i_rst          = 1'b1;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        model_reset();
        last_rd = 32'h0;
        @(negedge i_clk);
        check("t6 stall after rst", {31'b0, bus.o_dmem_stall}, 32'h0);
        check("t6 rdata after rst", bus.o_dmem_data, 32'h0);
        @(posedge i_clk);
        #1;
        do_req("t6 reread", 1'b1, 4'h0, 32'h0000_00A8, 32'h0, st);
        check("t6 stall const", 32'(st), 32'(LAT + 1));
        check("t6 data const", bus.o_dmem_data, 32'h5A5A_1234);
        do_req("t6 read 0x1C", 1'b1, 4'h0, 32'h1C, 32'h0, st);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end
endmodule
